// File: rtl/sd_sector_write_scheduler.sv
// -----------------------------------------------------------------------------
// sd_sector_write_scheduler
//
// Sequences whole-sector writes into the SD write master. Once the card is
// initialised and logging is enabled, a full sector's worth of FIFO words
// triggers a single-cycle wr_en. The transfer is then supervised: busy must
// rise, busy must fall, and exactly WORDS_PER_SECTOR wr_req cycles must be
// seen. Any failure latches a sticky error that clr_err releases, and the
// same sector address is retried. Addresses walk a ring that starts at
// START_SECTOR and holds SECTOR_COUNT sectors.
//
// Build option:
//   SD_SCHED_WRAP_EN  defined   -> ring wraps back to START_SECTOR, ring_wrap
//                                  pulses, log_full tied 0.
//                     undefined -> after the last ring sector the block parks
//                                  in FULL (log_full=1), ring_wrap tied 0.
//
// Ports:
//   sys_clk          in   system clock
//   sys_rst_n        in   asynchronous active-low reset
//   init_end         in   SD card initialisation complete (level)
//   log_en           in   permits new sector writes (sampled in WAIT_DATA)
//   clr_err          in   pulse, clears the sticky error
//   fifo_count[11:0] in   FIFO words currently readable
//   wr_busy          in   write master busy
//   wr_req           in   write master word request
//   wr_en            out  registered one-cycle write start pulse
//   wr_addr[31:0]    out  sector address of the current or next write
//   sector_done      out  one-cycle pulse on clean sector completion
//   sectors_written  out  saturating count of clean completions
//   ring_wrap        out  one-cycle pulse when wr_addr returns to the base
//   log_full         out  ring exhausted (no-wrap build only)
//   err              out  sticky error flag
//   err_code[1:0]    out  01 no busy rise, 10 busy stuck, 11 word mismatch
// -----------------------------------------------------------------------------
module sd_sector_write_scheduler #(
    parameter logic [11:0] WORDS_PER_SECTOR = 12'd256,
    parameter logic [31:0] START_SECTOR     = 32'd1000,
    parameter logic [31:0] SECTOR_COUNT     = 32'd1024,
    parameter logic [23:0] BUSY_TIMEOUT     = 24'd5_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        log_en,
    input  logic        clr_err,
    input  logic [11:0] fifo_count,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic        sector_done,
    output logic [31:0] sectors_written,
    output logic        ring_wrap,
    output logic        log_full,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_WAIT_FALL = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERROR     = 3'd6,
        ST_FULL      = 3'd7
    } state_t;

    localparam logic [31:0] LAST_SECTOR = START_SECTOR + SECTOR_COUNT - 32'd1;
    localparam logic [23:0] TMO_LAST    = BUSY_TIMEOUT - 24'd1;

    localparam logic [1:0] ERR_NO_RISE  = 2'b01;
    localparam logic [1:0] ERR_STUCK    = 2'b10;
    localparam logic [1:0] ERR_MISMATCH = 2'b11;

    state_t      state_r;
    logic [23:0] tmo_cnt_r;
    logic [11:0] word_cnt_r;
    logic        busy_d_r;
    logic        wr_en_r;
    logic        sector_done_r;
    logic        err_r;
    logic [1:0]  err_code_r;
    logic [31:0] wr_addr_r;
    logic [31:0] sectors_written_r;
`ifdef SD_SCHED_WRAP_EN
    logic        ring_wrap_r;
`else
    logic        log_full_r;
`endif

    logic tmo_hit_s;
    logic busy_fall_s;
    logic threshold_s;

    // Saturating increment so the completion count never rolls back to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

    assign tmo_hit_s   = (tmo_cnt_r == TMO_LAST);
    // Falling edge of busy: previous cycle high, this cycle low.
    assign busy_fall_s = busy_d_r & ~wr_busy;
    assign threshold_s = log_en & (fifo_count >= WORDS_PER_SECTOR);

    // Scheduler FSM; every output is a register updated here.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r           <= ST_IDLE;
            tmo_cnt_r         <= 24'd0;
            word_cnt_r        <= 12'd0;
            busy_d_r          <= 1'b0;
            wr_en_r           <= 1'b0;
            sector_done_r     <= 1'b0;
            err_r             <= 1'b0;
            err_code_r        <= 2'b00;
            wr_addr_r         <= START_SECTOR;
            sectors_written_r <= 32'd0;
`ifdef SD_SCHED_WRAP_EN
            ring_wrap_r       <= 1'b0;
`else
            log_full_r        <= 1'b0;
`endif
        end else begin
            busy_d_r      <= wr_busy;
            wr_en_r       <= 1'b0;
            sector_done_r <= 1'b0;
`ifdef SD_SCHED_WRAP_EN
            ring_wrap_r   <= 1'b0;
`endif
            // The timeout counter only advances while a wait state is held;
            // any transition (state entry) leaves it at zero.
            tmo_cnt_r     <= 24'd0;

            case (state_r)
                ST_IDLE: begin
                    if (init_end) begin
                        state_r <= ST_WAIT_DATA;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_WAIT_DATA: begin
                    // Losing card init takes priority over a ready sector.
                    if (!init_end) begin
                        state_r <= ST_IDLE;
                    end else if (threshold_s) begin
                        state_r <= ST_ISSUE;
                    end else begin
                        state_r <= ST_WAIT_DATA;
                    end
                end

                ST_ISSUE: begin
                    wr_en_r    <= 1'b1;
                    word_cnt_r <= 12'd0;
                    state_r    <= ST_WAIT_RISE;
                end

                ST_WAIT_RISE: begin
                    if (wr_busy) begin
                        state_r <= ST_WAIT_FALL;
                    end else if (tmo_hit_s) begin
                        state_r    <= ST_ERROR;
                        err_r      <= 1'b1;
                        err_code_r <= ERR_NO_RISE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 24'd1;
                    end
                end

                ST_WAIT_FALL: begin
                    if (wr_req && (word_cnt_r != 12'hFFF)) begin
                        word_cnt_r <= word_cnt_r + 12'd1;
                    end else begin
                        word_cnt_r <= word_cnt_r;
                    end
                    if (busy_fall_s) begin
                        state_r <= ST_DONE;
                    end else if (tmo_hit_s) begin
                        state_r    <= ST_ERROR;
                        err_r      <= 1'b1;
                        err_code_r <= ERR_STUCK;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 24'd1;
                    end
                end

                ST_DONE: begin
                    if (word_cnt_r != WORDS_PER_SECTOR) begin
                        // Address is left alone so the retry rewrites it.
                        state_r    <= ST_ERROR;
                        err_r      <= 1'b1;
                        err_code_r <= ERR_MISMATCH;
                    end else begin
                        sector_done_r     <= 1'b1;
                        sectors_written_r <= sat_inc32(sectors_written_r);
                        if (wr_addr_r == LAST_SECTOR) begin
`ifdef SD_SCHED_WRAP_EN
                            wr_addr_r   <= START_SECTOR;
                            ring_wrap_r <= 1'b1;
                            state_r     <= ST_WAIT_DATA;
`else
                            wr_addr_r   <= LAST_SECTOR + 32'd1;
                            log_full_r  <= 1'b1;
                            state_r     <= ST_FULL;
`endif
                        end else begin
                            wr_addr_r <= wr_addr_r + 32'd1;
                            state_r   <= ST_WAIT_DATA;
                        end
                    end
                end

                ST_ERROR: begin
                    if (clr_err) begin
                        state_r    <= ST_WAIT_DATA;
                        err_r      <= 1'b0;
                        err_code_r <= 2'b00;
                    end else begin
                        state_r <= ST_ERROR;
                    end
                end

                ST_FULL: begin
                    state_r <= ST_FULL;
                end

                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_en           = wr_en_r;
    assign wr_addr         = wr_addr_r;
    assign sector_done     = sector_done_r;
    assign sectors_written = sectors_written_r;
    assign err             = err_r;
    assign err_code        = err_code_r;
`ifdef SD_SCHED_WRAP_EN
    assign ring_wrap       = ring_wrap_r;
    assign log_full        = 1'b0;
`else
    assign ring_wrap       = 1'b0;
    assign log_full        = log_full_r;
`endif

endmodule
